// File: rtl/dlx_pkg.sv
// dlx_pkg: shared DLX fetch-path types and constants
package dlx_pkg;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc_next;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small instruction buffer between the memory response and the IF/ID register
module fetch_fifo
    import dlx_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
)(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [CW-1:0] count,
    output logic         empty
);
    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic full, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk)
        if (reset_n && !flush && push) mem[wr_ptr] <= din;

    always_ff @(posedge clk)
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(do_pop);
        end

    // the request credit rule keeps this unreachable
    always_ff @(posedge clk)
        if (reset_n && !flush && push) assert (!full || do_pop);
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: DLX IF stage - fetch PC, memory request credit, response buffering, IF/ID register
module fetch_stage
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_OUT = 2
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_ex,
    input  logic [31:0] target_ex,
    input  logic        redirect_id,
    input  logic [31:0] target_id,
    output logic        i_req,
    output logic [31:0] i_addr,
    input  logic        i_gnt,
    input  logic        i_rvalid,
    input  logic [31:0] i_rdata,
    output logic [31:0] instr_ID,
    output logic [31:0] PC_ID,
    output logic        valid_ID
);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0] pc_f, pc_resp, target, credit;
    logic [OW-1:0] outstanding, drop_cnt;
    logic [CW-1:0] fifo_count;
    logic redirect, grant, live, bypass, push, pop, fifo_empty;
    fetch_entry_t head, resp;

    assign redirect = redirect_ex || redirect_id;
    assign target = redirect_ex ? target_ex : target_id;
    // live requests plus buffered words must never exceed the buffer
    assign credit = 32'(outstanding) - 32'(drop_cnt) + 32'(fifo_count);
    assign i_req = reset_n && !redirect && 32'(outstanding) < MAX_OUT && credit < FIFO_DEPTH;
    assign i_addr = pc_f;
    assign grant = i_req && i_gnt;
    assign live = i_rvalid && drop_cnt == '0 && !redirect;
    assign resp = '{insn: i_rdata, pc_next: pc_resp + 32'd4};
    assign bypass = live && fifo_empty && !stall;
    assign push = live && !bypass;
    assign pop = !redirect && !stall && !fifo_empty;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .flush(redirect),
        .push(push),
        .pop(pop),
        .din(resp),
        .dout(head),
        .count(fifo_count),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk)
        if (!reset_n) begin
            pc_f <= RESET_PC;
            pc_resp <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
        end else begin
            outstanding <= outstanding + OW'(grant) - OW'(i_rvalid);
            pc_f <= redirect ? target : grant ? pc_f + 32'd4 : pc_f;
            pc_resp <= redirect ? target : live ? pc_resp + 32'd4 : pc_resp;
            drop_cnt <= redirect ? outstanding - OW'(i_rvalid)
                      : (i_rvalid && drop_cnt != '0) ? drop_cnt - OW'(1) : drop_cnt;
        end

    // a redirect squashes IF/ID even while ID is stalled
    always_ff @(posedge clk)
        if (!reset_n) begin
            instr_ID <= NOP_INSN;
            PC_ID <= '0;
            valid_ID <= 1'b0;
        end else if (redirect) begin
            instr_ID <= NOP_INSN;
            valid_ID <= 1'b0;
        end else if (!stall) begin
            instr_ID <= pop ? head.insn : bypass ? resp.insn : NOP_INSN;
            PC_ID <= pop ? head.pc_next : bypass ? resp.pc_next : PC_ID;
            valid_ID <= pop || bypass;
        end
endmodule
